// File: rtl/counter_prog_if.sv
// Control/status bundle for the programmable counter.
interface counter_prog_if #(
  parameter int unsigned N = 16
);
  logic         en;
  logic         up;
  logic         mode;
  logic [N-1:0] step;
  logic [N-1:0] limit;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] cmp;
  logic [N-1:0] count;
  logic         ovf_pulse;
  logic         match;

  modport master (
    output en, up, mode, step, limit, load, load_val, cmp,
    input  count, ovf_pulse, match
  );

  modport slave (
    input  en, up, mode, step, limit, load, load_val, cmp,
    output count, ovf_pulse, match
  );
endinterface

// File: rtl/counter_prog.sv
// Programmable up/down counter with runtime modulus, step size, parallel load,
// wrap/saturate mode, boundary-crossing pulse and compare match.
module counter_prog #(
  parameter int unsigned    N       = 16,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_prog_if.slave  bus
);

  logic [N-1:0] count_q, count_d;
  logic         ovf;

  // All arithmetic is N+1 bits wide so limit+1 and count+step never overflow.
  logic [N:0] cnt_ext, lim_ext, lim_p1, step_ext, s;
  logic [N:0] sum_up, wrap_up, diff_dn, wrap_dn;

  // Effective step and candidate next values for every branch.
  always_comb begin
    cnt_ext  = {1'b0, count_q};
    lim_ext  = {1'b0, bus.limit};
    step_ext = {1'b0, bus.step};
    lim_p1   = lim_ext + 1'b1;
    s        = (step_ext > lim_p1) ? lim_p1 : step_ext;
    sum_up   = cnt_ext + s;
    wrap_up  = sum_up - lim_p1;
    diff_dn  = cnt_ext - s;
    // Only used when count < s, so the result is at most limit.
    wrap_dn  = (lim_p1 - s) + cnt_ext;
  end

  // Next count and crossing pulse; priority is load over en.
  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (bus.en) begin
      if (count_q > bus.limit) begin
        // Limit was lowered below the current count: pull back into range.
        count_d = (!bus.mode && bus.up) ? '0 : bus.limit;
        ovf     = 1'b1;
      end else if (bus.up) begin
        if (sum_up <= lim_ext) begin
          count_d = sum_up[N-1:0];
        end else if (!bus.mode) begin
          count_d = wrap_up[N-1:0];
          ovf     = 1'b1;
        end else begin
          count_d = bus.limit;
          ovf     = (count_q != bus.limit);
        end
      end else begin
        if (cnt_ext >= s) begin
          count_d = diff_dn[N-1:0];
        end else if (!bus.mode) begin
          count_d = wrap_dn[N-1:0];
          ovf     = 1'b1;
        end else begin
          count_d = '0;
          ovf     = (count_q != '0);
        end
      end
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  // Drive the status outputs.
  always_comb begin
    bus.count     = count_q;
    bus.ovf_pulse = ovf;
    bus.match     = (count_q == bus.cmp);
  end

endmodule

// File: doc/counter_prog.md
Name: counter_prog

Overview:
- Programmable up/down counter; next generation of the fixed-modulus wrap counter.
- Adds a runtime limit (modulus), a step size, a synchronous parallel load, and a wrap/saturate mode.
- Outputs a boundary-crossing pulse and a compare-match flag.
- Used as the timebase/event counter for PWM, timers and rate dividers; the pulse output chains into the next stage's en.

Parameters:
- N, 16, counter/limit/step/compare width in bits.
- RST_VAL, 0, count value after reset; must be less than or equal to the limit in use.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; one step per enabled cycle.
- up  in  1  1 = count up, 0 = count down.
- mode  in  1  0 = wrap, 1 = saturate.
- step  in  N  increment/decrement magnitude.
- limit  in  N  maximum count value; legal range is 0..limit.
- load  in  1  synchronous parallel load strobe.
- load_val  in  N  value for load.
- cmp  in  N  compare value.
- count  out  N  current count (registered).
- ovf_pulse  out  1  boundary-crossing indication (combinational).
- match  out  1  count == cmp (combinational from count).

Behaviour:
- Reset: when rst_n=0 at a clock edge, count <= RST_VAL. While count=RST_VAL, ovf_pulse follows its combinational rule and match = (RST_VAL==cmp).
- Priority order: reset > load > en. With en=0 and load=0, count holds.
- Load:
  - count <= min(load_val, limit) on the next edge.
  - ovf_pulse=0 in a load cycle, even if en=1. Load consumes the cycle; no step is applied.
- Effective step: s = min(step, limit+1), computed in N+1 bits. No intermediate result may overflow; all sums and differences use N+1 bits.
- step=0: count holds, ovf_pulse=0.
- Up, in range (count <= limit):
  - If count+s <= limit: count <= count+s, ovf_pulse=0.
  - Else, wrap mode: count <= count+s-(limit+1), ovf_pulse=1.
  - Else, saturate mode: count <= limit, ovf_pulse=1 only if count != limit before the step. Saturated and held means no repeated pulse.
- Down, in range:
  - If count >= s: count <= count-s, ovf_pulse=0.
  - Else, wrap mode: count <= count+(limit+1)-s, ovf_pulse=1.
  - Else, saturate mode: count <= 0, ovf_pulse=1 only if count != 0 before the step.
- Out of range (count > limit, e.g. limit lowered at runtime) with en=1 and load=0:
  - count <= 0 if (wrap mode and up); otherwise count <= limit.
  - ovf_pulse=1.
- Out of range with en=0: count holds; no correction and no pulse.
- ovf_pulse is valid in the same cycle as the step that causes it. It is a pure function of en, load, up, mode, step, limit and count. Its qualifier is en=1 and load=0.
- limit=0: every up or down enabled step with s=1 is a crossing. In wrap mode count stays 0 and ovf_pulse=1 every enabled cycle.
- limit = 2^N-1 and step=1 reproduces the legacy fixed counter exactly:
  - pulse when en and count==MAX (up);
  - pulse when en and count==0 (down).
- Direction, mode, step and limit may change on any cycle. Each cycle's update uses that cycle's values.
- No internal state besides count. Latency from en to count update is one clock.

Test Plan:
- Reset: N=8, RST_VAL=5, rst_n=0 for 2 cycles with en=1 -> count=5; with cmp=5 -> match=1.
- Legacy compatibility: limit=255, step=1, up=1, wrap mode, load 254 then en for 3 cycles -> count 255, 0, 1. ovf_pulse=1 only in the cycle count=255. Repeat down from 1 -> count 0, 255 with pulse at count=0.
- Modular step: limit=9, step=4, up, wrap mode, start 0 -> count 4, 8, 2 (pulse), 6, 0 (pulse). Down from 1 with step=4 -> count 7, pulse=1.
- Saturate: limit=9, step=4, up, start 8 -> count 9 with pulse; next enabled cycle count stays 9 with pulse=0. Down from 2 -> count 0 with pulse, then 0 with no pulse.
- Load priority and clamp: load=1, en=1, load_val=200, limit=100 -> count=100, ovf_pulse=0. Mid-count, reset asserted together with load -> count=RST_VAL.
- Limit lowered: count=50, limit changed to 20, en=0 -> count holds at 50. Then en=1, up, wrap mode -> count=0 with pulse. Repeat in saturate mode -> count=20 with pulse. Also step=0 -> count holds and no pulse in range.
